// File: rtl/ram_responder_pkg.sv
// Shared types and constants for the RAM responder: FSM state encoding,
// the poison word returned on out-of-range reads, and address helpers.
package ram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic [31:0] BAD_READ_WORD = 32'h0BADF00D;
  localparam int          WORD_BYTES    = 4;
  localparam int          WORD_SHIFT    = $clog2(WORD_BYTES);

  // True when no byte-address bit above the word index is set.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth_log2);
    return (addr >> (depth_log2 + WORD_SHIFT)) == 32'd0;
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Core-side RAM request/acknowledge bus; the core is the master and the
// memory responder the slave.
interface ram_responder_if;

  logic        readReq;
  logic        writeReq;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic [31:0] ramIn;
  logic        readAck;
  logic        writeAck;

  modport master (
    output readReq, writeReq, ramAddress, ramOut,
    input  ramIn, readAck, writeAck
  );

  modport slave (
    input  readReq, writeReq, ramAddress, ramOut,
    output ramIn, readAck, writeAck
  );

endinterface

// File: rtl/ram_word_array.sv
// Single-port 32-bit word array with one write enable and a registered read;
// the read register always captures the word at the presented address.
module ram_word_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  // NOTE: storage has no reset so it maps onto RAM macros; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/ram_responder.sv
// Memory responder for the core RAM bus: one acknowledge per accepted request
// after LATENCY edges, plus a side load port usable while idle.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_responder_if.slave        bus,
  input  logic                  loadEn,
  input  logic [DEPTH_LOG2-1:0] loadAddr,
  input  logic [31:0]           loadData,
  output logic                  busy,
  output logic                  busErr
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e                state_q;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  is_write_q, in_range_q;
  logic [31:0]           ram_in_q;
  logic                  read_ack_q, write_ack_q, busy_q, bus_err_q;

  logic                  req, req_in_range, load_ok;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  arr_we;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [31:0]           arr_wdata, arr_rdata;

  assign req          = bus.readReq | bus.writeReq;
  assign req_idx      = bus.ramAddress[DEPTH_LOG2+WORD_SHIFT-1:WORD_SHIFT];
  assign req_in_range = addr_in_range(bus.ramAddress, DEPTH_LOG2);
  assign load_ok      = (state_q == IDLE) && loadEn && !req;
  assign cnt_d        = cnt_q - 4'd1;

  // In IDLE the array reads the incoming request's word so that LATENCY=1
  // has data ready in ACK; afterwards it stays on the latched index.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = idx_q;
    arr_wdata = wdata_q;
    if (state_q == IDLE) begin
      if (req) begin
        arr_addr = req_idx;
      end else begin
        arr_addr  = loadAddr;
        arr_wdata = loadData;
        arr_we    = loadEn;
      end
    end else if (state_q == ACK) begin
      arr_we = is_write_q && in_range_q;
    end
  end

  ram_word_array #(.ADDR_W(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      is_write_q  <= 1'b0;
      in_range_q  <= 1'b0;
      ram_in_q    <= 32'd0;
      read_ack_q  <= 1'b0;
      write_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      read_ack_q  <= 1'b0;
      write_ack_q <= 1'b0;
      if ((req && state_q != IDLE) || (loadEn && !load_ok)) bus_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req) begin
            idx_q      <= req_idx;
            wdata_q    <= bus.ramOut;
            is_write_q <= bus.writeReq;
            in_range_q <= req_in_range;
            cnt_q      <= CNT_INIT;
            busy_q     <= 1'b1;
            state_q    <= (LATENCY == 1) ? ACK : WAIT;
            if ((bus.readReq && bus.writeReq) || !req_in_range) bus_err_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == 4'd0) state_q <= ACK;
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (is_write_q) begin
            write_ack_q <= 1'b1;
          end else begin
            read_ack_q <= 1'b1;
            ram_in_q   <= in_range_q ? arr_rdata : BAD_READ_WORD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ramIn    = ram_in_q;
  assign bus.readAck  = read_ack_q;
  assign bus.writeAck = write_ack_q;
  assign busy         = busy_q;
  assign busErr       = bus_err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: three instances (LATENCY 1, 3, 4) share
// one stimulus stream; each is checked for timing, data and error flags.
module tb_ram_responder;

  localparam int LAT [3] = '{1, 3, 4};

  typedef enum logic [1:0] {K_LOAD, K_READ, K_WRITE, K_BOTH} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] ram_addr = 32'd0, ram_out = 32'd0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'd0;
  logic [31:0] load_data = 32'd0;

  logic [2:0]  rack, wack, busyv, errv;
  logic [31:0] rdat [3];

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = 32'd0;

  int          w_first [3];
  int          w_good  [3];
  int          w_bad   [3];
  logic [31:0] w_got   [3];
  logic        w_busy  [3];

  vec_t        vecs [16];

  always #5 clk = ~clk;

  ram_responder_if if_a ();
  ram_responder_if if_b ();
  ram_responder_if if_c ();

  assign if_a.readReq = rd;  assign if_a.writeReq = wr;
  assign if_a.ramAddress = ram_addr;  assign if_a.ramOut = ram_out;
  assign if_b.readReq = rd;  assign if_b.writeReq = wr;
  assign if_b.ramAddress = ram_addr;  assign if_b.ramOut = ram_out;
  assign if_c.readReq = rd;  assign if_c.writeReq = wr;
  assign if_c.ramAddress = ram_addr;  assign if_c.ramOut = ram_out;

  ram_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .bus(if_a.slave), .loadEn(load_en),
    .loadAddr(load_addr), .loadData(load_data), .busy(busyv[0]), .busErr(errv[0]));
  ram_responder #(.DEPTH_LOG2(8), .LATENCY(3)) u_b (
    .clk(clk), .reset(reset), .bus(if_b.slave), .loadEn(load_en),
    .loadAddr(load_addr), .loadData(load_data), .busy(busyv[1]), .busErr(errv[1]));
  ram_responder #(.DEPTH_LOG2(8), .LATENCY(4)) u_c (
    .clk(clk), .reset(reset), .bus(if_c.slave), .loadEn(load_en),
    .loadAddr(load_addr), .loadData(load_data), .busy(busyv[2]), .busErr(errv[2]));

  assign rack = {if_c.readAck, if_b.readAck, if_a.readAck};
  assign wack = {if_c.writeAck, if_b.writeAck, if_a.writeAck};
  assign rdat[0] = if_a.ramIn;
  assign rdat[1] = if_b.ramIn;
  assign rdat[2] = if_c.ramIn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Samples acknowledges on negedges start_c..end_c (the caller is already at
  // negedge start_c); records the first expected-kind ack per instance.
  task automatic watch(input logic w, input int start_c, input int end_c);
    for (int i = 0; i < 3; i++) begin
      w_first[i] = 0; w_good[i] = 0; w_bad[i] = 0; w_got[i] = 32'd0; w_busy[i] = 1'b1;
    end
    for (int c = start_c; c <= end_c; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (w ? wack[i] : rack[i]) begin
          w_good[i]++;
          if (w_first[i] == 0) begin
            w_first[i] = c; w_got[i] = rdat[i]; w_busy[i] = busyv[i];
          end
        end
        if (w ? rack[i] : wack[i]) w_bad[i]++;
      end
      if (c < end_c) @(negedge clk);
    end
  endtask

  task automatic txn(input logic r, input logic w, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] exp_rd,
                     input logic exp_err, input string nm);
    rd = r; wr = w; ram_addr = addr; ram_out = data;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 3; i++) check($sformatf("%s L%0d busy", nm, LAT[i]), 32'(busyv[i]), 32'd1);
    watch(w, 1, 7);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s L%0d ack cycle", nm, LAT[i]), w_first[i], LAT[i] + 1);
      check($sformatf("%s L%0d ack count", nm, LAT[i]), w_good[i], 1);
      check($sformatf("%s L%0d wrong ack", nm, LAT[i]), w_bad[i], 0);
      check($sformatf("%s L%0d busy at ack", nm, LAT[i]), 32'(w_busy[i]), 32'd0);
      if (w) check($sformatf("%s L%0d ramIn held", nm, LAT[i]), rdat[i], last_rd);
      else   check($sformatf("%s L%0d ramIn", nm, LAT[i]), w_got[i], exp_rd);
      check($sformatf("%s L%0d busErr", nm, LAT[i]), 32'(errv[i]), 32'(exp_err));
    end
    if (!w) last_rd = exp_rd;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_rd = 32'd0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{K_LOAD,  32'd3,          32'h12345678, 32'h0,        1'b0};
    vecs[1]  = '{K_READ,  32'd12,         32'h0,        32'h12345678, 1'b0};
    vecs[2]  = '{K_WRITE, 32'd8,          32'hCAFEF00D, 32'h0,        1'b0};
    vecs[3]  = '{K_READ,  32'd10,         32'h0,        32'hCAFEF00D, 1'b0};
    vecs[4]  = '{K_LOAD,  32'd0,          32'h11110000, 32'h0,        1'b0};
    vecs[5]  = '{K_LOAD,  32'd1,          32'h22221111, 32'h0,        1'b0};
    vecs[6]  = '{K_READ,  32'd0,          32'h0,        32'h11110000, 1'b0};
    vecs[7]  = '{K_READ,  32'd4,          32'h0,        32'h22221111, 1'b0};
    vecs[8]  = '{K_READ,  32'd8,          32'h0,        32'hCAFEF00D, 1'b0};
    vecs[9]  = '{K_LOAD,  32'd255,        32'hA5A55A5A, 32'h0,        1'b0};
    vecs[10] = '{K_READ,  32'h000003FF,   32'h0,        32'hA5A55A5A, 1'b0};
    vecs[11] = '{K_READ,  32'h00001000,   32'h0,        32'h0BADF00D, 1'b1};
    vecs[12] = '{K_WRITE, 32'h80000000,   32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[13] = '{K_READ,  32'd0,          32'h0,        32'h11110000, 1'b1};
    vecs[14] = '{K_BOTH,  32'd4,          32'hDEADBEEF, 32'h0,        1'b1};
    vecs[15] = '{K_READ,  32'd4,          32'h0,        32'hDEADBEEF, 1'b1};

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset L%0d readAck", LAT[i]), 32'(rack[i]), 32'd0);
      check($sformatf("reset L%0d writeAck", LAT[i]), 32'(wack[i]), 32'd0);
      check($sformatf("reset L%0d ramIn", LAT[i]), rdat[i], 32'd0);
      check($sformatf("reset L%0d busy", LAT[i]), 32'(busyv[i]), 32'd0);
      check($sformatf("reset L%0d busErr", LAT[i]), 32'(errv[i]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      case (vecs[v].kind)
        K_LOAD:  load(vecs[v].addr[7:0], vecs[v].data);
        K_READ:  txn(1'b1, 1'b0, vecs[v].addr, vecs[v].data, vecs[v].exp_rd, vecs[v].exp_err, $sformatf("vec%0d rd", v));
        K_WRITE: txn(1'b0, 1'b1, vecs[v].addr, vecs[v].data, vecs[v].exp_rd, vecs[v].exp_err, $sformatf("vec%0d wr", v));
        default: txn(1'b1, 1'b1, vecs[v].addr, vecs[v].data, vecs[v].exp_rd, vecs[v].exp_err, $sformatf("vec%0d both", v));
      endcase
    end

    // Reset while a write to word 3 is pending: nothing acknowledged, word kept.
    wr = 1'b1; ram_addr = 32'd12; ram_out = 32'hFFFFFFFF;
    @(negedge clk);
    wr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midreset L%0d writeAck", LAT[i]), 32'(wack[i]), 32'd0);
      check($sformatf("midreset L%0d ramIn", LAT[i]), rdat[i], 32'd0);
      check($sformatf("midreset L%0d busy", LAT[i]), 32'(busyv[i]), 32'd0);
      check($sformatf("midreset L%0d busErr", LAT[i]), 32'(errv[i]), 32'd0);
    end
    reset = 1'b0;
    last_rd = 32'd0;
    watch(1'b1, 2, 8);
    for (int i = 0; i < 3; i++)
      check($sformatf("midreset L%0d late ack", LAT[i]), w_good[i] + w_bad[i], 0);
    txn(1'b1, 1'b0, 32'd12, 32'd0, 32'h12345678, 1'b0, "after reset rd");

    // Second read issued while the first is in flight: ignored, flagged.
    rd = 1'b1; ram_addr = 32'd12;
    @(negedge clk);
    ram_addr = 32'd4;
    @(negedge clk);
    rd = 1'b0;
    watch(1'b0, 2, 9);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("collide L%0d ack count", LAT[i]), w_good[i], 1);
      check($sformatf("collide L%0d ramIn", LAT[i]), w_got[i], 32'h12345678);
      check($sformatf("collide L%0d busErr", LAT[i]), 32'(errv[i]), 32'd1);
    end
    last_rd = 32'h12345678;

    // Load attempted while busy: dropped and flagged.
    pulse_reset();
    rd = 1'b1; ram_addr = 32'd12;
    @(negedge clk);
    rd = 1'b0;
    load_en = 1'b1; load_addr = 8'd3; load_data = 32'h0;
    @(negedge clk);
    load_en = 1'b0;
    watch(1'b0, 2, 8);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy load L%0d ack count", LAT[i]), w_good[i], 1);
      check($sformatf("busy load L%0d busErr", LAT[i]), 32'(errv[i]), 32'd1);
    end
    last_rd = 32'h12345678;
    txn(1'b1, 1'b0, 32'd12, 32'd0, 32'h12345678, 1'b1, "busy load rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
